// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: one request at a time over valid/ready, response after LATENCY cycles.
// Define DMEM_WSTRB_EN to add req_wstrb byte-enable stores.
module dmem_responder #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
`ifdef DMEM_WSTRB_EN
   input  logic [3:0]  req_wstrb,
`endif
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          accept;
   logic          access;

   logic          wr_q;
   logic [AW-1:0] idx_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic          err_q;

   logic [31:0]   mem [DEPTH];

   logic [AW-1:0] idx_c;
   logic          err_c;
   logic [3:0]    wstrb_c;

   // Decode the incoming request address.
   assign idx_c = req_addr[AW+1:2];
   assign err_c = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);

`ifdef DMEM_WSTRB_EN
   assign wstrb_c = req_wstrb;
`else
   assign wstrb_c = 4'hF;
`endif

   // Next-state logic; the counter counts down the remaining WAIT cycles.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      access  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               accept  = 1'b1;
               state_d = WAIT;
               cnt_d   = CW'(LATENCY - 1);
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               access  = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Request capture, registered outputs and memory access.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready  <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         wr_q       <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         err_q      <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         req_ready <= (state_d == IDLE);
         if (accept) begin
            wr_q    <= req_write;
            idx_q   <= idx_c;
            wdata_q <= req_wdata;
            wstrb_q <= wstrb_c;
            err_q   <= err_c;
         end
         if (access) begin
            resp_valid <= 1'b1;
            resp_err   <= err_q;
            resp_rdata <= (!wr_q && !err_q) ? mem[idx_q] : 32'h0;
            if (wr_q && !err_q) begin
               for (int unsigned k = 0; k < 4; k++) begin
                  if (wstrb_q[k]) begin
                     mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
                  end
               end
            end
         end else if (state_q == RESP && resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances with LATENCY 2, 1 and 4.
module tb_dmem_responder;

   logic        clk;
   logic        rst        [3];
   logic        req_valid  [3];
   logic        req_ready  [3];
   logic        req_write  [3];
   logic [31:0] req_addr   [3];
   logic [31:0] req_wdata  [3];
`ifdef DMEM_WSTRB_EN
   logic [3:0]  req_wstrb  [3];
`endif
   logic        resp_valid [3];
   logic        resp_ready [3];
   logic [31:0] resp_rdata [3];
   logic        resp_err   [3];

   int n_checks = 0;
   int n_fail   = 0;

   dmem_responder #(.DEPTH(64), .LATENCY(2)) u0 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef DMEM_WSTRB_EN
      .req_wstrb(req_wstrb[0]),
`endif
      .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]));

   dmem_responder #(.DEPTH(64), .LATENCY(1)) u1 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef DMEM_WSTRB_EN
      .req_wstrb(req_wstrb[1]),
`endif
      .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]));

   dmem_responder #(.DEPTH(64), .LATENCY(4)) u2 (
      .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_write(req_write[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
`ifdef DMEM_WSTRB_EN
      .req_wstrb(req_wstrb[2]),
`endif
      .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
      .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one request on instance d; returns the response and edges from acceptance to resp_valid.
   task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic consume,
                         output logic [31:0] rdata, output logic err, output int lat);
      int w;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_valid[d] = 1'b1;
      w = 0;
      while (!req_ready[d] && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      lat = 0;
      while (!resp_valid[d] && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      rdata = resp_rdata[d];
      err   = resp_err[d];
      if (consume) begin
         resp_ready[d] = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) rst[d] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if (req_ready[d] !== 1'b0 || resp_valid[d] !== 1'b0 || resp_rdata[d] !== 32'h0 || resp_err[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs[%0d]: got ready=%b valid=%b rdata=%h err=%b, want 0 0 00000000 0",
                     d, req_ready[d], resp_valid[d], resp_rdata[d], resp_err[d]);
         end
      end
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
         n_checks++;
         if (req_ready[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_idle_ready[%0d]: got %b, want 1", d, req_ready[d]);
         end
      end
   endtask

   task automatic test_store_load();
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, rd, er, lat);
      n_checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL store_0x10: got lat=%0d err=%b rdata=%h, want lat=2 err=0 rdata=00000000", lat, er, rd);
      end
      n_checks++;
      if (req_ready[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL ready_after_resp: got %b, want 1", req_ready[0]);
      end
      do_req(0, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
      n_checks++;
      if (lat !== 2 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL load_0x10: got lat=%0d err=%b rdata=%h, want lat=2 err=0 rdata=deadbeef", lat, er, rd);
      end
   endtask

   task automatic test_errors();
      logic [31:0] rd;
      logic        er;
      int          lat;
      do_req(0, 1'b1, 32'h12, 32'h12345678, 1'b1, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL misaligned_store: got err=%b rdata=%h, want err=1 rdata=00000000", er, rd);
      end
      do_req(0, 1'b1, 32'h110, 32'hFFFFFFFF, 1'b1, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL range_store: got err=%b rdata=%h, want err=1 rdata=00000000", er, rd);
      end
      do_req(0, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
      n_checks++;
      if (er !== 1'b0 || rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL mem_after_err_stores: got err=%b rdata=%h, want err=0 rdata=deadbeef", er, rd);
      end
      do_req(0, 1'b0, 32'h100, 32'h0, 1'b1, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL range_load_0x100: got err=%b rdata=%h, want err=1 rdata=00000000", er, rd);
      end
      do_req(0, 1'b0, 32'h13, 32'h0, 1'b1, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
         n_fail++;
         $display("FAIL misaligned_load: got err=%b rdata=%h, want err=1 rdata=00000000", er, rd);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] rd;
      logic        er;
      int          lat;
      resp_ready[0] = 1'b0;
      do_req(0, 1'b0, 32'h10, 32'h0, 1'b0, rd, er, lat);
      n_checks++;
      if (lat !== 2 || rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL bp_first_resp: got lat=%0d rdata=%h, want lat=2 rdata=deadbeef", lat, rd);
      end
      for (int c = 0; c < 5; c++) begin
         req_valid[0] = (c % 2 == 0);
         req_write[0] = 1'b1;
         req_addr[0]  = 32'h10;
         req_wdata[0] = 32'h0BAD0BAD;
         @(posedge clk); #1;
         n_checks++;
         if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'hDEADBEEF || resp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got valid=%b rdata=%h err=%b ready=%b, want 1 deadbeef 0 0",
                     c, resp_valid[0], resp_rdata[0], resp_err[0], req_ready[0]);
         end
      end
      req_valid[0]  = 1'b0;
      resp_ready[0] = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (req_ready[0] !== 1'b1 || resp_valid[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_release: got ready=%b valid=%b, want ready=1 valid=0", req_ready[0], resp_valid[0]);
      end
      do_req(0, 1'b0, 32'h10, 32'h0, 1'b1, rd, er, lat);
      n_checks++;
      if (rd !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL bp_no_corrupt: got rdata=%h, want deadbeef", rd);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vals [3];
      logic [31:0] rd;
      logic        er;
      int          lat;
      int          k;
      int          nresp;
      int          cyc;
      logic        acc;
      logic        hs;
      vals[0] = 32'hA0A0A0A0;
      vals[1] = 32'h0000FFFF;
      vals[2] = 32'h13579BDF;
      k = 0; nresp = 0; cyc = 0;
      resp_ready[1] = 1'b1;
      req_write[1]  = 1'b1;
      req_addr[1]   = 32'h0;
      req_wdata[1]  = vals[0];
      req_valid[1]  = 1'b1;
      while (nresp < 3 && cyc < 60) begin
         acc = req_valid[1] && req_ready[1];
         hs  = resp_valid[1] && resp_ready[1];
         if (hs) begin
            n_checks++;
            if (resp_err[1] !== 1'b0 || resp_rdata[1] !== 32'h0) begin
               n_fail++;
               $display("FAIL b2b_store_resp[%0d]: got err=%b rdata=%h, want 0 00000000", nresp, resp_err[1], resp_rdata[1]);
            end
         end
         @(posedge clk); #1;
         cyc++;
         if (hs) nresp++;
         if (acc) begin
            k++;
            if (k == 3) begin
               req_valid[1] = 1'b0;
            end else begin
               req_addr[1]  = 32'(4 * k);
               req_wdata[1] = vals[k];
            end
         end
      end
      req_valid[1] = 1'b0;
      n_checks++;
      if (nresp !== 3) begin
         n_fail++;
         $display("FAIL b2b_resp_count: got %0d responses in %0d cycles, want 3", nresp, cyc);
      end
      for (int i = 0; i < 3; i++) begin
         do_req(1, 1'b0, 32'(4 * i), 32'h0, 1'b1, rd, er, lat);
         n_checks++;
         if (rd !== vals[i] || er !== 1'b0 || lat !== 1) begin
            n_fail++;
            $display("FAIL b2b_load[%0d]: got rdata=%h err=%b lat=%0d, want %h 0 1", i, rd, er, lat, vals[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        seen;
      resp_ready[2] = 1'b1;
      do_req(2, 1'b1, 32'h24, 32'h12345678, 1'b1, rd, er, lat);
      n_checks++;
      if (lat !== 4 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL l4_store_0x24: got lat=%0d err=%b, want lat=4 err=0", lat, er);
      end
      req_write[2] = 1'b1;
      req_addr[2]  = 32'h20;
      req_wdata[2] = 32'h55AA55AA;
      req_valid[2] = 1'b1;
      @(posedge clk); #1;
      req_valid[2] = 1'b0;
      @(posedge clk); #1;
      rst[2] = 1'b1;
      @(posedge clk); #1;
      rst[2] = 1'b0;
      n_checks++;
      if (resp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_outputs: got valid=%b ready=%b, want 0 0", resp_valid[2], req_ready[2]);
      end
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (resp_valid[2]) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_no_resp: got resp_valid seen=%b, want 0", seen);
      end
      do_req(2, 1'b0, 32'h20, 32'h0, 1'b1, rd, er, lat);
      n_checks++;
      if (rd !== 32'h0 || er !== 1'b0 || lat !== 4) begin
         n_fail++;
         $display("FAIL midrst_load_0x20: got rdata=%h err=%b lat=%0d, want 00000000 0 4", rd, er, lat);
      end
      do_req(2, 1'b0, 32'h24, 32'h0, 1'b1, rd, er, lat);
      n_checks++;
      if (rd !== 32'h0 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst_mem_cleared: got rdata=%h err=%b, want 00000000 0", rd, er);
      end
   endtask

`ifdef DMEM_WSTRB_EN
   task automatic test_wstrb();
      logic [31:0] rd;
      logic        er;
      int          lat;
      req_wstrb[0] = 4'b1111;
      do_req(0, 1'b1, 32'h8, 32'h11223344, 1'b1, rd, er, lat);
      req_wstrb[0] = 4'b0101;
      do_req(0, 1'b1, 32'h8, 32'hAABBCCDD, 1'b1, rd, er, lat);
      req_wstrb[0] = 4'b0000;
      do_req(0, 1'b0, 32'h8, 32'h0, 1'b1, rd, er, lat);
      n_checks++;
      if (rd !== 32'h11BB33DD || er !== 1'b0) begin
         n_fail++;
         $display("FAIL wstrb_merge: got rdata=%h err=%b, want 11bb33dd 0", rd, er);
      end
      do_req(0, 1'b1, 32'h8, 32'hFFFFFFFF, 1'b1, rd, er, lat);
      n_checks++;
      if (er !== 1'b0) begin
         n_fail++;
         $display("FAIL wstrb_zero_resp: got err=%b, want 0", er);
      end
      do_req(0, 1'b0, 32'h8, 32'h0, 1'b1, rd, er, lat);
      n_checks++;
      if (rd !== 32'h11BB33DD) begin
         n_fail++;
         $display("FAIL wstrb_zero_nochange: got rdata=%h, want 11bb33dd", rd);
      end
      req_wstrb[0] = 4'b1111;
   endtask
`endif

   initial begin
      for (int d = 0; d < 3; d++) begin
         rst[d]        = 1'b1;
         req_valid[d]  = 1'b0;
         req_write[d]  = 1'b0;
         req_addr[d]   = '0;
         req_wdata[d]  = '0;
         resp_ready[d] = 1'b1;
`ifdef DMEM_WSTRB_EN
         req_wstrb[d]  = 4'b1111;
`endif
      end
      test_reset();
      test_store_load();
      test_errors();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
`ifdef DMEM_WSTRB_EN
      test_wstrb();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
